ro_counter_ctrl: RTL and testbench
==================================

Name: ro_counter_ctrl

Overview:
Responder side of the roen / counter_ctrl_state handshake used by the RO PUF bit-generation controller. When roen is raised, it counts rising edges of the two selected ring oscillators over a fixed clock window and compares the counts. It then presents one signature bit with counter_ctrl_state = 2'b11 and holds it until roen is dropped. It also drives the RO-pair select index, which advances once per completed bit.

Parameters:
WINDOW_CYCLES, 1024, clk cycles per measurement window (>= 2)
CNT_W, 16, width of each RO edge counter (saturating)
SEL_W, 7, width of the RO-pair select index (128 pairs)

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-low (asserted when 0)
roen  in  1  measurement request from the bit-generation controller; level, 4-phase
ro_a  in  1  oscillator A output of the selected pair; asynchronous to clk
ro_b  in  1  oscillator B output of the selected pair; asynchronous to clk
counter_ctrl_state  out  2  FSM state: 00 IDLE, 01 COUNT, 10 COMPARE, 11 DONE
sig_bit  out  1  signature bit; valid while counter_ctrl_state == 2'b11
ro_sel  out  SEL_W  RO-pair select index for the oscillator muxes

Behaviour:
- Reset (rst == 0, async): state IDLE, counter_ctrl_state = 00, sig_bit = 0, ro_sel = 0, both counters = 0, window timer = 0, synchronizer flops = 0. All outputs are registered.
- RO input path: each RO passes through a 2-flop synchronizer plus 1 history flop. An edge pulse is sync2 & ~hist. Edges are counted only in COUNT. ROs are required to be slower than clk/2; faster ROs undercount, and this is not detected.
- IDLE: counters and timer held at 0. If roen == 1, go to COUNT the next cycle.
- COUNT: lasts exactly WINDOW_CYCLES cycles. The timer runs from 0 to WINDOW_CYCLES-1, then the FSM goes to COMPARE. Each counter increments on its edge pulse and saturates at 2^CNT_W-1 with no wrap.
- Abort: if roen == 0 in any COUNT cycle, go to IDLE next cycle. Counters and timer are cleared, sig_bit is unchanged, ro_sel does not advance.
- COMPARE: 1 cycle. Register sig_bit = (cnt_a > cnt_b). Equal counts give 0. Always goes to DONE.
- DONE: counter_ctrl_state = 11 and sig_bit is held. Stay in DONE while roen == 1. When roen == 0, go to IDLE and increment ro_sel in the same edge. ro_sel wraps from 2^SEL_W-1 to 0.
- Handshake latency: from roen rising to counter_ctrl_state == 11 is 1 (IDLE to COUNT) + WINDOW_CYCLES + 1 (COMPARE) cycles. The requester holds roen high for at least 1 cycle after seeing 11. The responder holds 11 for as long as roen stays high.
- roen high in DONE with no drop: remain in DONE indefinitely with no new measurement. A new measurement requires roen to go low and then high again.
- roen already high on arrival in IDLE (immediate re-request): go to COUNT the next cycle. IDLE therefore lasts a minimum of 1 cycle.
- The ro_sel change must settle through the RO muxes before the next COUNT. The minimum of 1 IDLE cycle plus 2 synchronizer cycles covers this. Edges captured during the first 2 COUNT cycles may come from mux switching; they are counted equally for A and B and are accepted.
- Reset asserted mid-operation returns everything to reset values immediately. The first operation after reset release uses ro_sel = 0.

Decomposition:
- Shared package/include: the 2-bit state encodings (IDLE, COUNT, COMPARE, DONE), the DONE value 2'b11 that the requester compares against, and the default WINDOW_CYCLES, CNT_W and SEL_W.
- Sub-module ro_edge_counter, instantiated twice for A and B:
  - inputs: clk, rst, ro, clr, en
  - output: count [CNT_W-1:0], saturating
  - contains the synchronizer and the edge detect.
- Top level: FSM, window timer, compare, ro_sel.

Test Plan (WINDOW_CYCLES = 64 unless noted):
- A faster: ro_a period 4 clk, ro_b period 8 clk, roen held high -> 11 appears 66 cycles after roen rises; cnt_a = 16±1, cnt_b = 8±1; sig_bit = 1; drop roen -> IDLE next cycle, ro_sel = 1.
- B faster: periods swapped -> sig_bit = 0; ro_sel advances to 2 on roen drop.
- Equal counts: both ROs period 8 clk in phase -> cnt_a == cnt_b = 8, sig_bit = 0.
- Abort: drop roen at COUNT cycle 30 -> IDLE next cycle, counters 0, ro_sel unchanged, sig_bit keeps its previous value, 11 never asserted.
- Saturation (CNT_W = 4): both ROs period 2 clk -> both counts stick at 15, no wrap, sig_bit = 0.
- Wrap/reset: 128 complete handshakes -> ro_sel returns to 0. Pull rst low at COUNT cycle 10 (async, mid-cycle) -> state 00, sig_bit 0, ro_sel 0 immediately. After release with roen high, a full 66-cycle measurement follows.

Source files
------------

// File: rtl/ro_counter_ctrl_pkg.sv
// Shared definitions for the RO PUF counter controller: the FSM state
// encodings seen by the requester, the DONE code it compares against, and
// the default sizing of the measurement datapath.
package ro_counter_ctrl_pkg;

    // Default sizing; the top module exposes these as overridable parameters.
    localparam int WINDOW_CYCLES_DEF = 1024;
    localparam int CNT_W_DEF         = 16;
    localparam int SEL_W_DEF         = 7;

    // Encodings are visible on counter_ctrl_state, so they are fixed values.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COUNT   = 2'b01,
        ST_COMPARE = 2'b10,
        ST_DONE    = 2'b11
    } ctrl_state_t;

    // Value of counter_ctrl_state that tells the requester sig_bit is valid.
    localparam logic [1:0] CTRL_DONE = 2'b11;

    // Width of a timer that counts 0 .. window-1; never narrower than 1 bit.
    function automatic int timer_width(input int window);
        int w;
        w = $clog2(window);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/ro_counter_ctrl_edge.sv
// Ring-oscillator edge counter. The RO is asynchronous to clk, so it is
// brought in through two synchronizer flops; a third history flop turns the
// synchronized level into a one-cycle pulse per rising edge. The counter
// saturates instead of wrapping so an over-fast oscillator can never look
// slower than it is.
module ro_edge_counter
    import ro_counter_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,    // asynchronous, active-low
    input  logic             ro,     // raw oscillator output
    input  logic             clr,    // synchronous clear, wins over en
    input  logic             en,     // count enable (COUNT window)
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic sync1;
    logic sync2;
    logic hist;
    logic edge_pulse;

    // Synchronizer and history flops run continuously so no false edge
    // appears when a window opens.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= ro;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign edge_pulse = sync2 & ~hist;

    // Saturating edge counter: clear has priority, then count enabled edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && edge_pulse && (count != CNT_MAX)) begin
            count <= count + CNT_ONE;
        end
    end

endmodule

// File: rtl/ro_counter_ctrl.sv
// Responder side of the roen / counter_ctrl_state handshake for the RO PUF
// bit generator. On request it counts rising edges of the two selected ring
// oscillators over a fixed window, compares them and presents one signature
// bit, then advances the RO-pair select once the requester releases roen.
//
// Handshake (4-phase, level): the requester raises roen and keeps it high.
// The responder moves IDLE -> COUNT -> COMPARE -> DONE and shows 2'b11 on
// counter_ctrl_state while sig_bit is valid; it holds 2'b11 for as long as
// roen stays high. Dropping roen in DONE completes the bit (IDLE, ro_sel+1);
// dropping it during COUNT aborts the measurement with no bit produced.
module ro_counter_ctrl
    import ro_counter_ctrl_pkg::*;
#(
    parameter int WINDOW_CYCLES = WINDOW_CYCLES_DEF,
    parameter int CNT_W         = CNT_W_DEF,
    parameter int SEL_W         = SEL_W_DEF
) (
    input  logic             clk,
    input  logic             rst,                 // asynchronous, active-low
    input  logic             roen,                // measurement request
    input  logic             ro_a,                // oscillator A, async
    input  logic             ro_b,                // oscillator B, async
    output logic [1:0]       counter_ctrl_state,  // current FSM state
    output logic             sig_bit,             // valid in DONE
    output logic [SEL_W-1:0] ro_sel               // RO-pair mux select
);

    localparam int                 TIMER_W    = timer_width(WINDOW_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(WINDOW_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
    localparam logic [SEL_W-1:0]   SEL_ONE    = SEL_W'(1);

    ctrl_state_t        state;
    ctrl_state_t        state_next;
    logic [TIMER_W-1:0] timer;
    logic               window_end;
    logic               cnt_clr;
    logic               cnt_en;
    logic               sel_adv;
    logic [CNT_W-1:0]   cnt_a;
    logic [CNT_W-1:0]   cnt_b;

    assign window_end = (timer == TIMER_LAST);

    // State register; the state itself is the registered handshake output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control decode. Counters are cleared in IDLE and on the
    // abort edge so a restarted measurement always begins from zero.
    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        sel_adv    = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_clr = 1'b1;
                if (roen) begin
                    state_next = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (!roen) begin
                    state_next = ST_IDLE;
                    cnt_clr    = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                    if (window_end) begin
                        state_next = ST_COMPARE;
                    end
                end
            end
            ST_COMPARE: begin
                state_next = ST_DONE;
            end
            ST_DONE: begin
                if (!roen) begin
                    state_next = ST_IDLE;
                    sel_adv    = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Window timer: runs 0 .. WINDOW_CYCLES-1 while counting, zero otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer <= '0;
        end else if ((state == ST_COUNT) && roen && !window_end) begin
            timer <= timer + TIMER_ONE;
        end else begin
            timer <= '0;
        end
    end

    ro_edge_counter #(
        .CNT_W (CNT_W)
    ) u_cnt_a (
        .clk   (clk),
        .rst   (rst),
        .ro    (ro_a),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (cnt_a)
    );

    ro_edge_counter #(
        .CNT_W (CNT_W)
    ) u_cnt_b (
        .clk   (clk),
        .rst   (rst),
        .ro    (ro_b),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (cnt_b)
    );

    // Signature bit: captured once in COMPARE, ties resolve to 0, held after.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sig_bit <= 1'b0;
        end else if (state == ST_COMPARE) begin
            sig_bit <= (cnt_a > cnt_b);
        end
    end

    // RO-pair select: advances only when a completed bit is released.
    // The following IDLE cycle plus the synchronizer depth let the muxes
    // settle before the next window starts counting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ro_sel <= '0;
        end else if (sel_adv) begin
            ro_sel <= ro_sel + SEL_ONE;
        end
    end

    assign counter_ctrl_state = state;

endmodule

// File: tb/tb_ro_counter_ctrl.sv
// Bench for ro_counter_ctrl: a 16-bit-counter instance and a 4-bit
// (saturating) instance share all inputs. Oscillators are modelled as
// periodic square waves; the reference counts their rising edges over the
// 64-cycle window directly from the waveform, with +/-1 tolerance for the
// synchronizer delay.
module tb_ro_counter_ctrl;

    localparam int WIN     = 64;
    localparam int LAT     = WIN + 2;
    localparam int SEL_MOD = 128;
    localparam int SAT_MAX = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       roen = 1'b0;
    logic       ro_a = 1'b0;
    logic       ro_b = 1'b0;
    logic [1:0] st;
    logic       sig;
    logic [6:0] sel;
    logic [1:0] st_s;
    logic       sig_s;
    logic [6:0] sel_s;

    int n_checks = 0;
    int n_fail   = 0;

    // Oscillator model and reference edge counts.
    int per_a = 8;
    int per_b = 8;
    int off_a = 0;
    int off_b = 0;
    int ph    = 0;
    bit win_on = 1'b0;
    int m_a = 0;
    int m_b = 0;

    // Expected outputs.
    int exp_sel = 0;
    bit exp_sig = 1'b0;

    ro_counter_ctrl #(.WINDOW_CYCLES(WIN), .CNT_W(16), .SEL_W(7)) dut (
        .clk                (clk),
        .rst                (rst),
        .roen               (roen),
        .ro_a               (ro_a),
        .ro_b               (ro_b),
        .counter_ctrl_state (st),
        .sig_bit            (sig),
        .ro_sel             (sel)
    );

    ro_counter_ctrl #(.WINDOW_CYCLES(WIN), .CNT_W(4), .SEL_W(7)) dut_sat (
        .clk                (clk),
        .rst                (rst),
        .roen               (roen),
        .ro_a               (ro_a),
        .ro_b               (ro_b),
        .counter_ctrl_state (st_s),
        .sig_bit            (sig_s),
        .ro_sel             (sel_s)
    );

    // Clock
    always #5 clk = ~clk;

    // Oscillator waveforms, updated on the falling edge; rising edges seen
    // while the window is open are counted by the reference.
    always @(negedge clk) begin
        logic na;
        logic nb;
        ph = ph + 1;
        na = (((ph + off_a) % per_a) < (per_a / 2));
        nb = (((ph + off_b) % per_b) < (per_b / 2));
        if (win_on && na && !ro_a) m_a = m_a + 1;
        if (win_on && nb && !ro_b) m_b = m_b + 1;
        ro_a = na;
        ro_b = nb;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic int clip(input int v);
        if (v > SAT_MAX) return SAT_MAX;
        if (v < 0) return 0;
        return v;
    endfunction

    // Driver: program the oscillators and let them run a few cycles.
    task automatic set_ro(input int pa, input int pb, input int oa, input int ob);
        @(posedge clk); #2;
        per_a = pa; per_b = pb; off_a = oa; off_b = ob;
        repeat (4) @(posedge clk);
        #2;
    endtask

    // Driver: raise roen and wait (bounded) for DONE; returns cycles taken.
    task automatic do_measure(output int lat);
        roen = 1'b1;
        m_a = 0; m_b = 0;
        win_on = 1'b1;
        lat = -1;
        for (int c = 1; c <= LAT + 20; c++) begin
            @(posedge clk); #1;
            if (c == WIN) win_on = 1'b0;
            if (st == 2'b11) begin
                lat = c;
                break;
            end
        end
        win_on = 1'b0;
    endtask

    // Check a completed measurement against the reference, then release.
    task automatic check_result(input string name, input int lat);
        int ca, cb, cas, cbs;
        bit exp_sig_s;
        ca  = int'(dut.u_cnt_a.count);
        cb  = int'(dut.u_cnt_b.count);
        cas = int'(dut_sat.u_cnt_a.count);
        cbs = int'(dut_sat.u_cnt_b.count);
        exp_sig   = (m_a > m_b);
        exp_sig_s = (clip(m_a) > clip(m_b));

        n_checks++;
        if (lat !== LAT) begin
            n_fail++; $display("FAIL %s latency: got %0d expected %0d", name, lat, LAT);
        end
        n_checks++;
        if (st_s !== 2'b11) begin
            n_fail++; $display("FAIL %s sat_state: got %b expected 11", name, st_s);
        end
        n_checks++;
        if (ca < m_a - 1 || ca > m_a + 1) begin
            n_fail++; $display("FAIL %s cnt_a: got %0d expected %0d+-1", name, ca, m_a);
        end
        n_checks++;
        if (cb < m_b - 1 || cb > m_b + 1) begin
            n_fail++; $display("FAIL %s cnt_b: got %0d expected %0d+-1", name, cb, m_b);
        end
        n_checks++;
        if (cas < clip(m_a - 1) || cas > clip(m_a + 1)) begin
            n_fail++; $display("FAIL %s sat_cnt_a: got %0d expected %0d+-1 clipped", name, cas, m_a);
        end
        n_checks++;
        if (cbs < clip(m_b - 1) || cbs > clip(m_b + 1)) begin
            n_fail++; $display("FAIL %s sat_cnt_b: got %0d expected %0d+-1 clipped", name, cbs, m_b);
        end
        n_checks++;
        if (sig !== exp_sig) begin
            n_fail++; $display("FAIL %s sig_bit: got %b expected %b", name, sig, exp_sig);
        end
        n_checks++;
        if (sig_s !== exp_sig_s) begin
            n_fail++; $display("FAIL %s sat_sig_bit: got %b expected %b", name, sig_s, exp_sig_s);
        end

        // DONE must hold while roen stays high.
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (st !== 2'b11 || sig !== exp_sig) begin
            n_fail++; $display("FAIL %s hold: got state %b sig %b expected 11 %b", name, st, sig, exp_sig);
        end

        roen = 1'b0;
        @(posedge clk); #1;
        exp_sel = (exp_sel + 1) % SEL_MOD;
        n_checks++;
        if (st !== 2'b00) begin
            n_fail++; $display("FAIL %s release_state: got %b expected 00", name, st);
        end
        n_checks++;
        if (sel !== 7'(exp_sel) || sel_s !== 7'(exp_sel)) begin
            n_fail++; $display("FAIL %s ro_sel: got %0d/%0d expected %0d", name, sel, sel_s, exp_sel);
        end
    endtask

    task automatic run_case(input string name, input int pa, input int pb,
                            input int oa, input int ob);
        int lat;
        set_ro(pa, pb, oa, ob);
        do_measure(lat);
        check_result(name, lat);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (st !== 2'b00 || sig !== 1'b0 || sel !== 7'd0 || dut.u_cnt_a.count !== 16'd0) begin
            n_fail++; $display("FAIL reset_values: got state %b sig %b sel %0d cnt %0d expected 00 0 0 0",
                               st, sig, sel, dut.u_cnt_a.count);
        end
        @(posedge clk); #2;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (st !== 2'b00) begin
            n_fail++; $display("FAIL reset_idle: got %b expected 00", st);
        end
    endtask

    task automatic test_a_faster();
        run_case("a_faster", 4, 8, 0, 0);
    endtask

    task automatic test_b_faster();
        run_case("b_faster", 8, 4, 0, 0);
    endtask

    task automatic test_equal();
        run_case("equal", 8, 8, 3, 3);
    endtask

    task automatic test_saturation();
        run_case("saturation", 2, 2, 0, 0);
    endtask

    task automatic test_abort();
        bit saw_done;
        bit prev_sig;
        prev_sig = exp_sig;
        saw_done = 1'b0;
        set_ro(4, 8, 0, 0);
        roen = 1'b1;
        for (int c = 1; c <= 31; c++) begin
            @(posedge clk); #1;
            if (st == 2'b11) saw_done = 1'b1;
        end
        roen = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (st !== 2'b00 || saw_done) begin
            n_fail++; $display("FAIL abort_state: got %b done_seen %0d expected 00 0", st, saw_done);
        end
        n_checks++;
        if (dut.u_cnt_a.count !== 16'd0 || dut.u_cnt_b.count !== 16'd0) begin
            n_fail++; $display("FAIL abort_counters: got %0d/%0d expected 0/0",
                               dut.u_cnt_a.count, dut.u_cnt_b.count);
        end
        n_checks++;
        if (sel !== 7'(exp_sel) || sig !== prev_sig) begin
            n_fail++; $display("FAIL abort_keep: got sel %0d sig %b expected %0d %b", sel, sig, exp_sel, prev_sig);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3; i++) begin
            int fast, slow;
            fast = $urandom_range(4, 6);
            slow = $urandom_range(10, 12);
            if ($urandom_range(0, 1) == 1)
                run_case("random_a", fast, slow, $urandom_range(0, fast - 1), $urandom_range(0, slow - 1));
            else
                run_case("random_b", slow, fast, $urandom_range(0, slow - 1), $urandom_range(0, fast - 1));
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        set_ro(4, 8, 0, 0);
        roen = 1'b1;
        repeat (11) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        n_checks++;
        if (st !== 2'b00 || sig !== 1'b0 || sel !== 7'd0 || st_s !== 2'b00) begin
            n_fail++; $display("FAIL reset_mid: got state %b sig %b sel %0d expected 00 0 0", st, sig, sel);
        end
        exp_sel = 0;
        @(posedge clk); #2;
        rst = 1'b1;
        do_measure(lat);
        check_result("after_reset", lat);
    endtask

    task automatic test_back_to_back();
        int n;
        n = SEL_MOD - exp_sel;
        for (int i = 0; i < n; i++) begin
            int waited;
            roen = 1'b1;
            waited = 0;
            while (st !== 2'b11 && waited < LAT + 10) begin
                @(posedge clk); #1;
                waited++;
            end
            roen = 1'b0;
            @(posedge clk); #1;
            exp_sel = (exp_sel + 1) % SEL_MOD;
            n_checks++;
            if (waited !== LAT || sel !== 7'(exp_sel)) begin
                n_fail++; $display("FAIL back_to_back: got wait %0d sel %0d expected %0d %0d",
                                   waited, sel, LAT, exp_sel);
            end
        end
        n_checks++;
        if (sel !== 7'd0) begin
            n_fail++; $display("FAIL sel_wrap: got %0d expected 0", sel);
        end
    endtask

    initial begin
        test_reset();
        test_a_faster();
        test_abort();
        test_b_faster();
        test_equal();
        test_saturation();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
